aca_err_monitor: RTL and testbench

Pipelined error-statistics collector placed directly downstream of the 32-bit approximate carry-select adder. Each cycle it accepts one operand pair and the adder's 33-bit approximate result, recomputes the exact sum internally, and accumulates error statistics over a programmed run length:
- error count
- summed absolute error distance
- maximum error distance
- index of the first erroneous sample

It replaces file-compare checking in hardware characterisation runs.

---
 rtl/aca_err_monitor.sv | 205 ++++++++++++++++++++
 tb/tb_aca_err_monitor.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aca_err_monitor.sv
// aca_err_monitor: error-statistics collector for the approximate carry-select adder.
// Latency: sample accepted at edge k updates statistics at k+2; done rises at k_last+3.
// Backpressure: registered in_ready, high only in RUN until num_samples accepted.
// Optional feature: define ACA_ERR_BIAS_EN to add the signed err_bias_sum output.
module aca_err_monitor #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 32,
  parameter int ACC_W = 48
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [CNT_W-1:0]   num_samples,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [WIDTH:0]     approx,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   err_count,
  output logic [ACC_W-1:0]   err_dist_sum,
  output logic [WIDTH:0]     max_err_dist,
  output logic [CNT_W-1:0]   first_err_idx
`ifdef ACA_ERR_BIAS_EN
  ,
  output logic signed [ACC_W-1:0] err_bias_sum
`endif
);

  // Unsigned accumulator needs one carry bit beyond the wider of its two operands.
  localparam int SW = ((ACC_W > WIDTH + 1) ? ACC_W : WIDTH + 1) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state, state_nxt;
  logic             start_run;
  logic [CNT_W-1:0] accepted;
  logic [CNT_W-1:0] target;
  logic [CNT_W-1:0] idx_nxt;
  logic             accept;
  logic             last_accept;

  // Stage 1 registers
  logic             s1_vld;
  logic [WIDTH-1:0] s1_a, s1_b;
  logic [WIDTH:0]   s1_ap;
  logic [CNT_W-1:0] s1_idx;

  // Stage 1 combinational results
  logic [WIDTH:0]          exact;
  logic signed [WIDTH+1:0] delta;
  logic [WIDTH:0]          diff;

  // Stage 2 registers
  logic             s2_vld;
  logic [WIDTH:0]   s2_diff;
  logic             s2_err;
  logic [CNT_W-1:0] s2_idx;

  // Accumulator next values
  logic [SW-1:0]    sum_ext;
  logic [ACC_W-1:0] sum_nxt;

  assign idx_nxt     = accepted + CNT_W'(1);
  assign accept      = in_valid && in_ready;
  assign last_accept = accept && (idx_nxt == target);
  assign busy        = (state == RUN) || (state == DRAIN);
  assign done        = (state == DONE);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; start_run marks the edge that clears statistics and latches the run length
  always_comb begin
    state_nxt = state;
    start_run = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          start_run = 1'b1;
          state_nxt = (num_samples == '0) ? DRAIN : RUN;
        end
      end
      RUN: begin
        if (last_accept) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (!s1_vld && !s2_vld) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Registered in_ready, run length and accepted-sample counter
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready <= 1'b0;
      accepted <= '0;
      target   <= '0;
    end else if (start_run) begin
      in_ready <= (num_samples != '0);
      accepted <= '0;
      target   <= num_samples;
    end else if (accept) begin
      accepted <= idx_nxt;
      if (last_accept) in_ready <= 1'b0;
    end
  end

  // Pipeline valid bits; reset discards anything in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld <= 1'b0;
      s2_vld <= 1'b0;
    end else begin
      s1_vld <= accept;
      s2_vld <= s1_vld;
    end
  end

  // Stage 1 capture of the accepted triple and its 1-based index
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_a   <= a;
      s1_b   <= b;
      s1_ap  <= approx;
      s1_idx <= idx_nxt;
    end
  end

  // Exact sum and absolute error distance; difference of two (WIDTH+1)-bit values fits WIDTH+2 signed
  always_comb begin
    exact = {1'b0, s1_a} + {1'b0, s1_b};
    delta = $signed({1'b0, s1_ap}) - $signed({1'b0, exact});
    diff  = delta[WIDTH+1] ? (WIDTH+1)'(-delta) : delta[WIDTH:0];
  end

  // Stage 2 capture of distance, error flag and index
  always_ff @(posedge clk) begin
    if (s1_vld) begin
      s2_diff <= diff;
      s2_err  <= (diff != '0);
      s2_idx  <= s1_idx;
    end
  end

  // Saturating distance sum: any carry above ACC_W bits pins the result to all-ones
  always_comb begin
    sum_ext = SW'(err_dist_sum) + SW'(s2_diff);
    sum_nxt = (|sum_ext[SW-1:ACC_W]) ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
  end

  // Stage 3 statistics accumulation; a zero error count identifies the first error
  always_ff @(posedge clk) begin
    if (rst || start_run) begin
      err_count     <= '0;
      err_dist_sum  <= '0;
      max_err_dist  <= '0;
      first_err_idx <= '0;
    end else if (s2_vld) begin
      err_count    <= err_count + CNT_W'(s2_err);
      err_dist_sum <= sum_nxt;
      if (s2_diff > max_err_dist) max_err_dist <= s2_diff;
      if (s2_err && (err_count == '0)) first_err_idx <= s2_idx;
    end
  end

`ifdef ACA_ERR_BIAS_EN
  // Signed accumulator wide enough that one addition cannot overflow before clamping.
  localparam int BW = ((ACC_W > WIDTH + 2) ? ACC_W : WIDTH + 2) + 1;

  logic signed [WIDTH+1:0] s2_delta;
  logic signed [BW-1:0]    bias_ext;
  logic signed [BW-1:0]    bias_max;
  logic signed [BW-1:0]    bias_min;
  logic signed [ACC_W-1:0] bias_nxt;

  // Stage 2 capture of the signed error
  always_ff @(posedge clk) begin
    if (s1_vld) s2_delta <= delta;
  end

  // Signed saturating bias sum against the ACC_W signed range
  always_comb begin
    bias_max = $signed({{(BW-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}});
    bias_min = $signed({{(BW-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}});
    bias_ext = $signed({{(BW-ACC_W){err_bias_sum[ACC_W-1]}}, err_bias_sum})
             + $signed({{(BW-WIDTH-2){s2_delta[WIDTH+1]}}, s2_delta});
    if (bias_ext > bias_max)      bias_nxt = bias_max[ACC_W-1:0];
    else if (bias_ext < bias_min) bias_nxt = bias_min[ACC_W-1:0];
    else                          bias_nxt = bias_ext[ACC_W-1:0];
  end

  // Bias statistic clears and updates alongside the other statistics
  always_ff @(posedge clk) begin
    if (rst || start_run) err_bias_sum <= '0;
    else if (s2_vld)      err_bias_sum <= bias_nxt;
  end
`endif

endmodule

// File: tb/tb_aca_err_monitor.sv
// Bench for aca_err_monitor: random and directed runs against a per-run reference model.
// Two instances share stimulus: default ACC_W and ACC_W=8 to exercise saturation.
`timescale 1ns/1ps
module tb_aca_err_monitor;
  localparam int WIDTH = 32;
  localparam int CNT_W = 32;
  localparam int ACC_W = 48;
  localparam int ACC_S = 8;

  logic              clk = 1'b0;
  logic              rst, start, in_valid;
  logic [CNT_W-1:0]  num_samples;
  logic [WIDTH-1:0]  a, b;
  logic [WIDTH:0]    approx;

  logic              in_ready, busy, done;
  logic [CNT_W-1:0]  err_count, first_err_idx;
  logic [ACC_W-1:0]  err_dist_sum;
  logic [WIDTH:0]    max_err_dist;

  logic              in_ready_s, busy_s, done_s;
  logic [CNT_W-1:0]  err_count_s, first_err_idx_s;
  logic [ACC_S-1:0]  err_dist_sum_s;
  logic [WIDTH:0]    max_err_dist_s;
`ifdef ACA_ERR_BIAS_EN
  logic signed [ACC_W-1:0] err_bias_sum;
  logic signed [ACC_S-1:0] err_bias_sum_s;
`endif

  aca_err_monitor #(.WIDTH(WIDTH), .CNT_W(CNT_W), .ACC_W(ACC_W)) u_dut (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .approx(approx),
    .busy(busy), .done(done), .err_count(err_count), .err_dist_sum(err_dist_sum),
    .max_err_dist(max_err_dist), .first_err_idx(first_err_idx)
`ifdef ACA_ERR_BIAS_EN
    , .err_bias_sum(err_bias_sum)
`endif
  );

  aca_err_monitor #(.WIDTH(WIDTH), .CNT_W(CNT_W), .ACC_W(ACC_S)) u_sat (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(in_ready_s), .a(a), .b(b), .approx(approx),
    .busy(busy_s), .done(done_s), .err_count(err_count_s), .err_dist_sum(err_dist_sum_s),
    .max_err_dist(max_err_dist_s), .first_err_idx(first_err_idx_s)
`ifdef ACA_ERR_BIAS_EN
    , .err_bias_sum(err_bias_sum_s)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH:0]   ap;
  } smp_t;

  smp_t dq[$];     // directed samples, consumed in order as they are accepted
  smp_t acc_q[$];  // samples actually accepted in the current run
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [WIDTH-1:0] pa, input logic [WIDTH-1:0] pb, input logic [WIDTH:0] pap);
    smp_t s;
    s.a = pa; s.b = pb; s.ap = pap;
    dq.push_back(s);
  endtask

  function automatic smp_t gen(input int err_pct);
    smp_t s;
    logic [WIDTH:0] ex;
    s.a = $urandom;
    s.b = $urandom;
    ex  = {1'b0, s.a} + {1'b0, s.b};
    if (int'($urandom_range(99)) >= err_pct) s.ap = ex;
    else begin
      case ($urandom_range(3))
        0: s.ap = ex + 33'($urandom_range(300, 1));
        1: s.ap = ex - 33'($urandom_range(300, 1));
        2: s.ap = 33'({$urandom, $urandom});
        default: s.ap = ($urandom_range(1) == 1) ? '0 : '1;
      endcase
    end
    return s;
  endfunction

  function automatic longint clamp(input longint v, input longint lo, input longint hi);
    return (v > hi) ? hi : ((v < lo) ? lo : v);
  endfunction

  // Reference statistics recomputed from the list of accepted samples
  task automatic check_stats(input string tag);
    longint cnt = 0, sum = 0, mx = 0, first = 0, bias_w = 0, bias_s = 0;
    longint lim_w = longint'(1) <<< (ACC_W - 1);
    longint lim_s = longint'(1) <<< (ACC_S - 1);
    foreach (acc_q[i]) begin
      longint ex, d, ad;
      ex = longint'(acc_q[i].a) + longint'(acc_q[i].b);
      d  = longint'(acc_q[i].ap) - ex;
      ad = (d < 0) ? -d : d;
      if (ad != 0) begin
        cnt++;
        if (first == 0) first = i + 1;
      end
      sum += ad;
      if (ad > mx) mx = ad;
      bias_w = clamp(bias_w + d, -lim_w, lim_w - 1);
      bias_s = clamp(bias_s + d, -lim_s, lim_s - 1);
    end
    check({tag, ".err_count"},     64'(err_count),     64'(cnt));
    check({tag, ".err_dist_sum"},  64'(err_dist_sum),  64'(sum));
    check({tag, ".max_err_dist"},  64'(max_err_dist),  64'(mx));
    check({tag, ".first_err_idx"}, 64'(first_err_idx), 64'(first));
    check({tag, ".s.err_count"},   64'(err_count_s),   64'(cnt));
    check({tag, ".s.err_dist_sum"},64'(err_dist_sum_s),64'((sum > 255) ? 255 : sum));
    check({tag, ".s.max_err_dist"},64'(max_err_dist_s),64'(mx));
`ifdef ACA_ERR_BIAS_EN
    check({tag, ".err_bias_sum"},   64'(err_bias_sum),   64'(bias_w));
    check({tag, ".s.err_bias_sum"}, 64'(err_bias_sum_s), 64'(bias_s));
`else
    if (bias_w != bias_s + bias_w - bias_s) $display("bias model inconsistent");
`endif
  endtask

  // One run: start pulse, stimulus with gaps, done timing, then statistics.
  // rst_after > 0 asserts reset on the edge right after that many accepts.
  task automatic run(input string tag, input int n, input int gap_pct,
                     input int err_pct, input int rst_after);
    int  acc = 0, last_e = 0, done_e = -1;
    int  budget = 20 * n + 60;
    smp_t s;
    acc_q.delete();
    @(negedge clk);
    start = 1'b1; num_samples = CNT_W'(n); in_valid = 1'b0;
    @(posedge clk); #1;
    check({tag, ".start_done"}, 64'(done), 64'(0));
    check({tag, ".start_busy"}, 64'(busy), 64'(1));
    check({tag, ".start_cleared"}, 64'(err_count | first_err_idx | max_err_dist),  64'(0));
    for (int c = 1; c <= budget && done_e < 0; c++) begin
      @(negedge clk);
      if (rst_after > 0 && acc == rst_after) begin
        check({tag, ".pre_rst_cnt"}, 64'(err_count), 64'(1));
        rst = 1'b1; start = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
        check({tag, ".rst_ready"}, 64'({in_ready, in_ready_s}), 64'(0));
        check({tag, ".rst_flags"}, 64'({busy, done, busy_s, done_s}), 64'(0));
        check({tag, ".rst_stats"}, 64'(err_count | first_err_idx | max_err_dist), 64'(0));
        check({tag, ".rst_sum"}, 64'(err_dist_sum) | 64'(err_dist_sum_s), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        dq.delete();
        return;
      end
      // start and num_samples wiggle while busy; the monitor must ignore both
      start       = ($urandom_range(9) == 0);
      num_samples = $urandom_range(5);
      check({tag, ".in_ready"}, 64'(in_ready), 64'((acc < n) ? 1 : 0));
      check({tag, ".s.in_ready"}, 64'(in_ready_s), 64'((acc < n) ? 1 : 0));
      in_valid = (int'($urandom_range(99)) >= gap_pct);
      s = (dq.size() > 0) ? dq[0] : gen(err_pct);
      a = s.a; b = s.b; approx = s.ap;
      if (in_valid && in_ready) begin
        acc_q.push_back(s);
        if (dq.size() > 0) void'(dq.pop_front());
        acc++;
        last_e = c;
      end
      @(posedge clk); #1;
      if (done) done_e = c;
      else check({tag, ".busy"}, 64'(busy), 64'(1));
    end
    @(negedge clk);
    start = 1'b0; in_valid = 1'b0;
    if (done_e < 0) begin
      check({tag, ".done_timeout"}, 64'(0), 64'(1));
      return;
    end
    check({tag, ".accepts"}, 64'(acc), 64'(n));
    check({tag, ".done_edge"}, 64'(done_e), 64'((n == 0) ? 1 : last_e + 3));
    check({tag, ".done_busy"}, 64'({busy, in_ready, done_s}), 64'(3'b001));
    check_stats(tag);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; num_samples = '0; in_valid = 1'b0;
    a = '0; b = '0; approx = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.ready", 64'({in_ready, in_ready_s}), 64'(0));
    check("reset.flags", 64'({busy, done}), 64'(0));
    check("reset.stats", 64'(err_count | first_err_idx | max_err_dist), 64'(0));
    check("reset.sum", 64'(err_dist_sum), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    // Exact results only, including the carry-out case
    push(32'h0000000F, 32'h00000001, 33'h010);
    push(32'hFFFFFFFF, 32'h00000001, 33'h100000000);
    push(32'h0, 32'h0, 33'h0);
    run("exact", 3, 0, 0, 0);
    check("exact.cnt", 64'(err_count), 64'(0));

    // Two errors at samples 2 and 4
    push(32'h1, 32'h2, 33'h3);
    push(32'h8, 32'h8, 33'h0);
    push(32'h5, 32'h5, 33'hA);
    push(32'hFF, 32'h0, 33'h1FF);
    run("errors", 4, 0, 0, 0);
    check("errors.cnt", 64'(err_count), 64'(2));
    check("errors.sum", 64'(err_dist_sum), 64'(33'h110));
    check("errors.max", 64'(max_err_dist), 64'(33'h100));
    check("errors.first", 64'(first_err_idx), 64'(2));
`ifdef ACA_ERR_BIAS_EN
    check("errors.bias", 64'(err_bias_sum), 64'(48'hF0));
`endif

    run("gaps", 2, 50, 40, 0);
    run("zero", 0, 0, 0, 0);
    check("zero.sum", 64'(err_dist_sum), 64'(0));

    // Narrow accumulator saturates
    push(32'h0, 32'h0, 33'hC8);
    push(32'h0, 32'h0, 33'hC8);
    run("sat", 2, 0, 0, 0);
    check("sat.sum8", 64'(err_dist_sum_s), 64'(8'hFF));
    check("sat.max8", 64'(max_err_dist_s), 64'(33'hC8));

    // Reset with errors 3 and 4 still in the pipeline
    push(32'h1, 32'h1, 33'h7);
    push(32'h1, 32'h1, 33'h2);
    push(32'h2, 32'h2, 33'h0);
    push(32'h3, 32'h3, 33'h1);
    for (int i = 0; i < 6; i++) push(32'h4, 32'h4, 33'h8);
    run("midrst", 10, 0, 0, 4);
    push(32'h10, 32'h20, 33'h30);
    run("afterrst", 1, 0, 0, 0);
    check("afterrst.cnt", 64'(err_count), 64'(0));

    for (int r = 0; r < 20; r++)
      run("rand", int'($urandom_range(40, 1)), int'($urandom_range(50)), 35, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
